// File: rtl/pb_pkg.sv
// Shared constants and helpers for the multi-channel pushbutton controller.
package pb_pkg;

  // Register offsets relative to the block base address.
  localparam logic [7:0] OFS_LEVEL = 8'd0;
  localparam logic [7:0] OFS_PRESS = 8'd1;
  localparam logic [7:0] OFS_REL   = 8'd2;

  // Returns {all_ones, all_zeros} over the history bits selected by mask.
  function automatic logic [1:0] reduce_all(input logic [7:0] sh, input logic [7:0] mask);
    logic all_ones;
    logic all_zeros;
    all_ones  = &(sh | ~mask);
    all_zeros = ~|(sh & mask);
    return {all_ones, all_zeros};
  endfunction

endpackage

// File: rtl/pb_chan.sv
// One pushbutton channel: synchroniser, sample history, debounced level,
// sticky press/release events and optional auto-repeat of press events.
module pb_chan
  import pb_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REP_W    = 8,
  parameter int REP_DLY  = 0,
  parameter int REP_RATE = 16,
  parameter bit REP_ON   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  input  logic tick,
  input  logic clr_press,
  input  logic clr_rel,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic [7:0]       SH_MASK = 8'((16'd1 << DEPTH) - 16'd1);
  localparam bit               REP_ACT = REP_ON && (REP_DLY != 0);
  localparam logic [REP_W-1:0] RC_DLY  = REP_W'(REP_DLY);
  localparam logic [REP_W-1:0] RC_RATE = REP_W'(REP_RATE);
  localparam logic [REP_W-1:0] RC_ONE  = REP_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic [DEPTH-1:0] sh_r;
  logic             level_r;
  logic             press_r;
  logic             rel_r;
  logic [REP_W-1:0] rc_r;
  logic [1:0]       red_s;
  logic             rise_s;
  logic             fall_s;
  logic             rep_fire_s;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pb_raw;
      sync2_r <= sync1_r;
    end
  end

  // Shift the synchronised input into the history on each prescaler tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r <= {DEPTH{1'b0}};
    end else if (tick) begin
      sh_r <= {sh_r[DEPTH-2:0], sync2_r};
    end
  end

  // Level edges are derived from a unanimous history disagreeing with the level.
  always_comb begin
    red_s      = reduce_all(8'(sh_r), SH_MASK);
    rise_s     = red_s[1] & ~level_r;
    fall_s     = red_s[0] & level_r;
    rep_fire_s = REP_ACT & level_r & tick & (rc_r == RC_ONE);
  end

  // Debounced level follows a unanimous history, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b0;
    end else if (red_s[1]) begin
      level_r <= 1'b1;
    end else if (red_s[0]) begin
      level_r <= 1'b0;
    end
  end

  // Sticky events: a set on the clearing edge wins so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_r <= 1'b0;
      rel_r   <= 1'b0;
    end else begin
      press_r <= rise_s | rep_fire_s | (press_r & ~clr_press);
      rel_r   <= fall_s | (rel_r & ~clr_rel);
    end
  end

  // Repeat counter: loaded on the press edge, counts ticks while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_r <= {REP_W{1'b0}};
    end else if (REP_ACT && rise_s) begin
      rc_r <= RC_DLY;
    end else if (REP_ACT && level_r && tick) begin
      if (rc_r == RC_ONE) begin
        rc_r <= RC_RATE;
      end else begin
        rc_r <= rc_r - RC_ONE;
      end
    end
  end

  assign level = level_r;
  assign press = press_r;
  assign rel   = rel_r;

endmodule

// File: rtl/pb_multi.sv
// Multi-channel pushbutton controller on an 8-bit memory-mapped read bus:
// shared prescaler, per-channel debouncers, register read mux and irq.
module pb_multi
  import pb_pkg::*;
#(
  parameter int              N_CH      = 5,
  parameter int              DIV_W     = 12,
  parameter int              DEPTH     = 3,
  parameter logic [7:0]      BASE_ADDR = 8'd253,
  parameter int              REP_W     = 8,
  parameter int              REP_DLY   = 0,
  parameter int              REP_RATE  = 16,
  parameter logic [N_CH-1:0] REP_EN    = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      addr,
  input  logic            rd,
  output logic [7:0]      out,
  input  logic [N_CH-1:0] pb,
  output logic            irq
);

  localparam logic [7:0] A_LEVEL = BASE_ADDR + OFS_LEVEL;
  localparam logic [7:0] A_PRESS = BASE_ADDR + OFS_PRESS;
  localparam logic [7:0] A_REL   = BASE_ADDR + OFS_REL;

  logic [DIV_W-1:0] cnt_r;
  logic             tick_s;
  logic             irq_r;
  logic             clr_press_s;
  logic             clr_rel_s;
  logic [N_CH-1:0]  level_v;
  logic [N_CH-1:0]  press_v;
  logic [N_CH-1:0]  rel_v;
  logic [7:0]       ext_level_s;
  logic [7:0]       ext_press_s;
  logic [7:0]       ext_rel_s;
  logic [7:0]       out_s;

  // Free-running prescaler; a tick is issued whenever it reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick_s = (cnt_r == {DIV_W{1'b0}});

  // Decode read-to-clear strobes for the two event registers.
  always_comb begin
    clr_press_s = 1'b0;
    clr_rel_s   = 1'b0;
    if (rd && (addr == A_PRESS)) begin
      clr_press_s = 1'b1;
    end else if (rd && (addr == A_REL)) begin
      clr_rel_s = 1'b1;
    end else begin
      clr_press_s = 1'b0;
      clr_rel_s   = 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_chan #(
      .DEPTH    (DEPTH),
      .REP_W    (REP_W),
      .REP_DLY  (REP_DLY),
      .REP_RATE (REP_RATE),
      .REP_ON   (REP_EN[i])
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .pb_raw    (pb[i]),
      .tick      (tick_s),
      .clr_press (clr_press_s),
      .clr_rel   (clr_rel_s),
      .level     (level_v[i]),
      .press     (press_v[i]),
      .rel       (rel_v[i])
    );
  end

  // Combinational read mux; unused upper bits and unmapped addresses read zero.
  always_comb begin
    ext_level_s = 8'd0;
    ext_press_s = 8'd0;
    ext_rel_s   = 8'd0;
    ext_level_s[N_CH-1:0] = level_v;
    ext_press_s[N_CH-1:0] = press_v;
    ext_rel_s[N_CH-1:0]   = rel_v;
    case (addr)
      A_LEVEL: out_s = ext_level_s;
      A_PRESS: out_s = ext_press_s;
      A_REL:   out_s = ext_rel_s;
      default: out_s = 8'd0;
    endcase
  end

  // Interrupt is a registered OR of all pending press events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |press_v;
    end
  end

  assign out = out_s;
  assign irq = irq_r;

endmodule
